// File: rtl/pkg_dtypes.sv
// Shared channel types between ALU, result cache and interconnect.
package pkg_dtypes;

  localparam int unsigned EuidxW = 2;
  localparam int unsigned UidW   = 4;
  localparam int unsigned SpecW  = 2;
  localparam int unsigned DataW  = 32;

  // Renamed operand address: owning EU, unique id, speculation tag.
  typedef struct packed {
    logic [EuidxW-1:0] euidx;
    logic [UidW-1:0]   uid;
    logic [SpecW-1:0]  spec;
  } type_opd_addr;

  typedef struct packed {
    logic [DataW-1:0] opd_data;
    type_opd_addr     opd_addr;
    logic             opd_valid;
  } type_alu_channel_tx;

  typedef struct packed {
    logic opd_store_success;
  } type_alu_channel_rx;

  typedef struct packed {
    logic [DataW-1:0] data_tx;
    logic             data_valid_tx;
    type_opd_addr     src_addr;
    logic             req_valid;
  } type_icon_tx_channel_chside;

  typedef struct packed {
    logic [DataW-1:0] data_rx;
    logic             data_valid_rx;
    logic             success;
  } type_icon_rx_channel_chside;

endpackage

// File: rtl/eu_result_cache.sv
// Per-EU result store: holds tagged ALU results until a single interconnect
// read consumes them. Writes handshake combinationally, reads respond one
// cycle later.
module eu_result_cache
  import pkg_dtypes::*;
#(
  parameter int unsigned EUIDX = 0,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       i_clk,
  input  logic                       i_nrst,
  input  type_alu_channel_tx         i_alu_tx,
  output logic                       o_opd_store_success,
  input  type_icon_tx_channel_chside i_icon_req,
  output type_icon_rx_channel_chside o_icon_rsp,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_full,
  output logic                       o_empty,
  output logic                       o_addr_err
);

  localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH) + 1;
  localparam int unsigned TagW = UidW + SpecW;
  localparam logic [EuidxW-1:0] OwnEu = EuidxW'(EUIDX);

  // Entry storage; euidx is implied by ownership and not kept.
  logic [DEPTH-1:0] valid_q;
  logic [TagW-1:0]  tag_q  [DEPTH];
  logic [DataW-1:0] data_q [DEPTH];

  logic [CntW-1:0]            count_q;
  type_icon_rx_channel_chside rsp_q, rsp_d;
  logic                       addr_err_q;

  logic [TagW-1:0] wr_tag, rd_tag;
  logic            wr_own, wr_foreign, wr_dup, free_found, wr_en;
  logic [IdxW-1:0] free_idx;
  logic            rd_own, rd_hit;
  logic [IdxW-1:0] hit_idx;

  // Data/valid-request fields on the request channel carry nothing for us.
  logic unused_icon;
  assign unused_icon = ^{i_icon_req.data_tx, i_icon_req.data_valid_tx};

  assign wr_tag     = {i_alu_tx.opd_addr.uid, i_alu_tx.opd_addr.spec};
  assign rd_tag     = {i_icon_req.src_addr.uid, i_icon_req.src_addr.spec};
  assign wr_own     = i_alu_tx.opd_valid && (i_alu_tx.opd_addr.euidx == OwnEu);
  assign wr_foreign = i_alu_tx.opd_valid && (i_alu_tx.opd_addr.euidx != OwnEu);
  assign rd_own     = i_icon_req.req_valid && (i_icon_req.src_addr.euidx == OwnEu);

  // Lowest free slot and duplicate-tag detection, both on start-of-cycle state.
  always_comb begin
    wr_dup     = 1'b0;
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        free_found = 1'b1;
        free_idx   = IdxW'(i);
      end
      if (valid_q[i] && (tag_q[i] == wr_tag)) begin
        wr_dup = 1'b1;
      end
    end
  end

  // Read lookup; tags are unique so at most one entry can match.
  always_comb begin
    rd_hit  = 1'b0;
    hit_idx = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (rd_own && valid_q[i] && (tag_q[i] == rd_tag)) begin
        rd_hit  = 1'b1;
        hit_idx = IdxW'(i);
      end
    end
  end

  assign wr_en = wr_own && free_found && !wr_dup;

  // Next response: entry data on a hit, all zeros otherwise.
  always_comb begin
    rsp_d = '0;
    if (rd_hit) begin
      rsp_d.data_rx       = data_q[hit_idx];
      rsp_d.data_valid_rx = 1'b1;
      rsp_d.success       = 1'b1;
    end
  end

  // Control state: valid bits, occupancy, response and sticky error.
  // A hit frees a valid slot and a write fills an invalid one, so they never collide.
  always_ff @(posedge i_clk) begin
    if (!i_nrst) begin
      valid_q    <= '0;
      count_q    <= '0;
      rsp_q      <= '0;
      addr_err_q <= 1'b0;
    end else begin
      if (wr_en) begin
        valid_q[free_idx] <= 1'b1;
      end
      if (rd_hit) begin
        valid_q[hit_idx] <= 1'b0;
      end
      count_q <= count_q + CntW'(wr_en) - CntW'(rd_hit);
      rsp_q   <= rsp_d;
      if (wr_foreign) begin
        addr_err_q <= 1'b1;
      end
    end
  end

  // Payload storage; contents are meaningless while the valid bit is clear.
  always_ff @(posedge i_clk) begin
    if (wr_en) begin
      tag_q[free_idx]  <= wr_tag;
      data_q[free_idx] <= i_alu_tx.opd_data;
    end
  end

  assign o_opd_store_success = wr_en;
  assign o_icon_rsp          = rsp_q;
  assign o_count             = count_q;
  assign o_full              = (count_q == CntW'(DEPTH));
  assign o_empty             = (count_q == '0);
  assign o_addr_err          = addr_err_q;

endmodule

// File: doc/eu_result_cache.md
# eu_result_cache

Per-execution-unit result store at the ALU output: the receiving end of the ALU `type_alu_channel_tx` channel and the responding end of the interconnect channel-side request (`type_icon_tx_channel_chside` in, `type_icon_rx_channel_chside` out). It accepts ALU results tagged with their renamed destination address. It holds each result until one interconnect read consumes it, then frees the slot. Back-pressure to the ALU pipeline is the `opd_store_success` bit of `type_alu_channel_rx`.

## Interface
Parameters:
- EUIDX, 0: index of the owning execution unit; only addresses with `euidx == EUIDX` are accepted.
- DEPTH, 4: number of result entries (power of two, 2..16).

Ports (all types from `pkg_dtypes`):
- i_clk  in  1  clock; single clock domain.
- i_nrst  in  1  reset; synchronous, active-low.
- i_alu_tx  in  $bits(type_alu_channel_tx)  ALU result: opd_data, opd_addr, opd_valid.
- o_opd_store_success  out  1  write accepted this cycle (combinational); routed into the ALU's `type_alu_channel_rx.opd_store_success`.
- i_icon_req  in  $bits(type_icon_tx_channel_chside)  interconnect request; uses req_valid and src_addr; data_tx/data_valid_tx ignored.
- o_icon_rsp  out  $bits(type_icon_rx_channel_chside)  registered response: data_rx, data_valid_rx, success.
- o_count  out  $clog2(DEPTH)+1  number of occupied entries.
- o_full, o_empty  out  1  occupancy flags (combinational from o_count).
- o_addr_err  out  1  sticky: an opd_valid write carried a foreign euidx.

## Operation
- Entry state: valid bit, tag `{uid, spec}`, data word. The euidx is not stored.
- Write acceptance: `o_opd_store_success = opd_valid && opd_addr.euidx == EUIDX && free entry exists && no valid entry already holds the same tag`. All four terms use state at the start of the cycle.
- On an accepting edge, the lowest-index free entry is written and its valid bit is set.
- Duplicate tag: the write is rejected and the producer holds and retries. Aliasing is never allowed.
- Foreign euidx with opd_valid=1: the write is rejected and o_addr_err is set. o_addr_err clears only on reset.
- Read: when req_valid=1, src_addr is compared against all valid tags. A src_addr with a foreign euidx is always a miss.
  - Hit: on the next edge the response carries success=1, data_valid_rx=1 and data_rx = entry data, and the entry's valid bit clears (single consumer).
  - Miss: success=0, data_valid_rx=0, data_rx=0.
- With req_valid=0, the next response is all zeros.
- Simultaneous write and read in one cycle:
  - A read never sees a same-cycle write (no bypass); a read to the tag being written misses.
  - A slot freed by a read is not reusable for a write in the same cycle. o_full reflects start-of-cycle state.
  - o_count update = +1 if write accepted, −1 if read hit, net 0 if both occur.
- Reset (i_nrst=0 at an edge): all valid bits, o_icon_rsp, o_count and o_addr_err go to 0. Data contents are don't-care. o_empty=1 and o_full=0 follow from o_count.
- Reset mid-operation drops all stored results; an in-flight response is replaced by zeros on the following cycle.

## Timing
- Write: 0-cycle handshake. success is combinational from i_alu_tx and registered state. Data is stored at the edge and readable from the next cycle's request.
- Read: request at cycle N, response valid in cycle N+1, held for exactly one cycle.
- Back-to-back requests are supported every cycle. Throughput is 1 write + 1 read per cycle.
- Minimum write-to-consume latency: write at N, request at N+1, response at N+2.

## Test plan
- Reset then single write/read:
  - Reset: o_empty=1, o_count=0, o_icon_rsp=0.
  - Write uid=1/spec=2, data=0xA5 with EUIDX matching: success=1 the same cycle.
  - Request at the next cycle: response success=1, data_rx=0xA5 one cycle later; o_count returns to 0.
- Fill and back-pressure:
  - DEPTH=4: write 4 distinct tags → o_full=1.
  - 5th write: o_opd_store_success=0 while held.
  - Read one tag: the held write is accepted the cycle after the read's edge, not the same cycle.
- Duplicate and foreign addresses:
  - Write an existing tag → rejected, o_count unchanged.
  - Write with euidx≠EUIDX → rejected, o_addr_err=1 and it stays set until reset.
- Simultaneous events:
  - Same cycle: write tag T and request T → response is a miss.
  - Request T again next cycle → hit.
  - Concurrent write of a new tag and hit of an old tag → o_count unchanged.
- Miss and consume-once: reading the same tag twice gives success=1 then success=0. A never-written tag gives success=0 with data_rx=0.
- Reset mid-operation: with 3 entries valid and a hit response pending, assert i_nrst=0 for one edge → response zero, o_count=0, and all prior tags miss afterwards.
